// File: rtl/vga_timing_ctrl_pkg.sv
// Shared 640x480@60 VGA timing constants and sync polarity.
// Pattern generators import this package so that every block uses the same values.
package vga_timing_ctrl_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;

    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    // Both syncs are active-low in this mode.
    localparam logic SYNC_ACTIVE = 1'b0;

    function automatic logic in_window(
        logic [9:0] v,
        logic [9:0] lo,
        logic [9:0] hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_wrap_counter.sv
// Enabled up-counter that wraps MAX->0 and flags the wrapping cycle.
// RST_VAL lets the raster counters park at their last value out of reset.
module wrap_counter #(
    parameter int WIDTH   = 10,
    parameter int MAX     = 799,
    parameter int RST_VAL = MAX
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

    // Count up on enable, wrapping back to zero after MAX.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_o <= RST_V;
        end else if (en_i) begin
            count_o <= (count_o == MAX_V) ? '0 : count_o + WIDTH'(1);
        end
    end

    assign wrap_o = en_i && (count_o == MAX_V);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: column/row counters, sync/visible decode,
// frame-start pulse and a test-pattern index stepped every N frames.
module vga_timing_ctrl
    import vga_timing_ctrl_pkg::*;
#(
    parameter int FRAMES_PER_PATTERN = 60,
    parameter int NUM_PATTERNS       = 4,
    parameter int H_VISIBLE          = VGA_H_VISIBLE,
    parameter int H_FRONT            = VGA_H_FRONT,
    parameter int H_SYNC             = VGA_H_SYNC,
    parameter int H_BACK             = VGA_H_BACK,
    parameter int V_VISIBLE          = VGA_V_VISIBLE,
    parameter int V_FRONT            = VGA_V_FRONT,
    parameter int V_SYNC             = VGA_V_SYNC,
    parameter int V_BACK             = VGA_V_BACK
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       pix_en_i,
    input  logic       hold_i,
    output logic [9:0] column_o,
    output logic [9:0] row_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       visible_o,
    output logic       frame_start_o,
    output logic [1:0] pattern_o
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] H_VIS_V  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_V  = 10'(V_VISIBLE);

    localparam int FC_W =
        (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FRAMES_PER_PATTERN - 1);
    localparam logic [1:0]      PAT_LAST = 2'(NUM_PATTERNS - 1);

    logic            h_wrap;
    logic            v_wrap;
    logic            f_wrap;
    logic            frame_cnt_en;
    logic [FC_W-1:0] frame_cnt;
    logic            primed;
    logic            frame_start_q;
    logic [1:0]      pattern_q;

    // The wrap out of the reset position opens frame 1 but completes no frame.
    assign frame_cnt_en = v_wrap & primed & ~hold_i;

    wrap_counter #(
        .WIDTH   (10),
        .MAX     (H_TOTAL - 1),
        .RST_VAL (H_TOTAL - 1)
    ) u_h_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (pix_en_i),
        .count_o (column_o),
        .wrap_o  (h_wrap)
    );

    wrap_counter #(
        .WIDTH   (10),
        .MAX     (V_TOTAL - 1),
        .RST_VAL (V_TOTAL - 1)
    ) u_v_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (h_wrap),
        .count_o (row_o),
        .wrap_o  (v_wrap)
    );

    wrap_counter #(
        .WIDTH   (FC_W),
        .MAX     (FRAMES_PER_PATTERN - 1),
        .RST_VAL (0)
    ) u_f_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (frame_cnt_en),
        .count_o (frame_cnt),
        .wrap_o  (f_wrap)
    );

    // Remember that the raster has left its reset position.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            primed <= 1'b0;
        end else if (pix_en_i) begin
            primed <= 1'b1;
        end
    end

    // Pulse for the one cycle in which the counters first show (0,0).
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= v_wrap;
        end
    end

    // Step the pattern on the same edge that starts the new frame.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pattern_q <= 2'd0;
        end else if (f_wrap && (frame_cnt == FC_LAST)) begin
            pattern_q <= (pattern_q == PAT_LAST) ? 2'd0 : pattern_q + 2'd1;
        end
    end

    assign hsync_o = in_window(column_o, HS_FIRST, HS_LAST)
                     ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vsync_o = in_window(row_o, VS_FIRST, VS_LAST)
                     ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign visible_o     = (column_o < H_VIS_V) && (row_o < V_VIS_V);
    assign frame_start_o = frame_start_q;
    assign pattern_o     = pattern_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: full-size instance for line-level timing,
// scaled instance for frame, pattern, hold and reset sequencing.
module tb_vga_timing_ctrl;

    localparam int A_HT  = 800;
    localparam int A_VT  = 525;
    localparam int A_HS0 = 656;
    localparam int A_HS1 = 751;
    localparam int A_VS0 = 490;
    localparam int A_VS1 = 491;
    localparam int A_HV  = 640;
    localparam int A_VV  = 480;

    localparam int B_HT  = 15;
    localparam int B_VT  = 9;
    localparam int B_HS0 = 10;
    localparam int B_HS1 = 12;
    localparam int B_VS0 = 5;
    localparam int B_VS1 = 6;
    localparam int B_HV  = 8;
    localparam int B_VV  = 4;
    localparam int B_FR  = B_HT * B_VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n, en_a, hold_a;
    logic [9:0] col_a, row_a;
    logic       hs_a, vs_a, vis_a, fs_a;
    logic [1:0] pat_a;

    logic       rst_b_n, en_b, hold_b;
    logic [9:0] col_b, row_b;
    logic       hs_b, vs_b, vis_b, fs_b;
    logic [1:0] pat_b;

    logic [23:0] got_a, got_b;
    assign got_a = {col_a, row_a, hs_a, vs_a, vis_a, fs_a};
    assign got_b = {col_b, row_b, hs_b, vs_b, vis_b, fs_b};

    int checks = 0;
    int failures = 0;

    vga_timing_ctrl dut_a (
        .clk_i         (clk),
        .rst_n_i       (rst_a_n),
        .pix_en_i      (en_a),
        .hold_i        (hold_a),
        .column_o      (col_a),
        .row_o         (row_a),
        .hsync_o       (hs_a),
        .vsync_o       (vs_a),
        .visible_o     (vis_a),
        .frame_start_o (fs_a),
        .pattern_o     (pat_a)
    );

    vga_timing_ctrl #(
        .FRAMES_PER_PATTERN (2),
        .NUM_PATTERNS       (4),
        .H_VISIBLE          (8),
        .H_FRONT            (2),
        .H_SYNC             (3),
        .H_BACK             (2),
        .V_VISIBLE          (4),
        .V_FRONT            (1),
        .V_SYNC             (2),
        .V_BACK             (2)
    ) dut_b (
        .clk_i         (clk),
        .rst_n_i       (rst_b_n),
        .pix_en_i      (en_b),
        .hold_i        (hold_b),
        .column_o      (col_b),
        .row_o         (row_b),
        .hsync_o       (hs_b),
        .vsync_o       (vs_b),
        .visible_o     (vis_b),
        .frame_start_o (fs_b),
        .pattern_o     (pat_b)
    );

    // Reference model: linear pixel index within the frame.
    int lin_a = A_HT * A_VT - 1;
    bit mfs_a = 0;
    int lin_b = B_FR - 1;
    bit mfs_b = 0;
    int entered_b = 0;
    int counted_b = 0;

    function automatic logic [23:0] exp_vec(
        int lin, bit fs, int ht, int hs0, int hs1,
        int vs0, int vs1, int hv, int vv
    );
        int c;
        int r;
        c = lin % ht;
        r = lin / ht;
        return {10'(c), 10'(r), !(c >= hs0 && c <= hs1),
                !(r >= vs0 && r <= vs1), (c < hv && r < vv), fs};
    endfunction

    function automatic logic [23:0] exp_a();
        return exp_vec(lin_a, mfs_a, A_HT, A_HS0, A_HS1,
                       A_VS0, A_VS1, A_HV, A_VV);
    endfunction

    function automatic logic [23:0] exp_b();
        return exp_vec(lin_b, mfs_b, B_HT, B_HS0, B_HS1,
                       B_VS0, B_VS1, B_HV, B_VV);
    endfunction

    // Pattern = completed, non-held frames / 2, modulo 4.
    function automatic logic [1:0] exp_pat_b();
        return 2'((counted_b / 2) % 4);
    endfunction

    task automatic step_a(input bit rst, input bit en);
        if (!rst) begin
            lin_a = A_HT * A_VT - 1;
            mfs_a = 0;
        end else if (en) begin
            lin_a = (lin_a + 1) % (A_HT * A_VT);
            mfs_a = (lin_a == 0);
        end else begin
            mfs_a = 0;
        end
    endtask

    task automatic step_b(input bit rst, input bit en, input bit hold);
        if (!rst) begin
            lin_b = B_FR - 1;
            mfs_b = 0;
            entered_b = 0;
            counted_b = 0;
        end else if (en) begin
            if (lin_b == B_FR - 1) begin
                entered_b++;
                if (entered_b > 1 && !hold) counted_b++;
            end
            lin_b = (lin_b + 1) % B_FR;
            mfs_b = (lin_b == 0);
        end else begin
            mfs_b = 0;
        end
    endtask

    // Drive at the falling edge, clock once, return at the next falling edge.
    task automatic cyc(input bit ra, input bit ea, input bit ha,
                       input bit rb, input bit eb, input bit hb);
        rst_a_n = ra; en_a = ea; hold_a = ha;
        rst_b_n = rb; en_b = eb; hold_b = hb;
        @(posedge clk);
        step_a(ra, ea);
        step_b(rb, eb, hb);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1'($urandom), 1'($urandom), 0, 1'($urandom), 1'($urandom));
            checks++;
            if (got_a !== {10'd799, 10'd524, 4'b1100}) begin
                failures++;
                $display("FAIL reset_a got=%h exp=%h", got_a,
                         {10'd799, 10'd524, 4'b1100});
            end
            checks++;
            if (pat_a !== 2'd0) begin
                failures++;
                $display("FAIL reset_pat_a got=%0d exp=0", pat_a);
            end
            checks++;
            if ({got_b, pat_b} !== {exp_b(), 2'd0}) begin
                failures++;
                $display("FAIL reset_b got=%h exp=%h", {got_b, pat_b},
                         {exp_b(), 2'd0});
            end
        end
    endtask

    task automatic test_first_cycle();
        cyc(1, 1, 0, 1, 1, 0);
        checks++;
        if (got_a !== {10'd0, 10'd0, 4'b1111}) begin
            failures++;
            $display("FAIL first_cycle_a got=%h exp=%h", got_a,
                     {10'd0, 10'd0, 4'b1111});
        end
        checks++;
        if ({got_b, pat_b} !== {exp_b(), 2'd0}) begin
            failures++;
            $display("FAIL first_cycle_b got=%h exp=%h", {got_b, pat_b},
                     {exp_b(), 2'd0});
        end
    endtask

    task automatic test_line();
        int hs_low;
        int first_low;
        int vis_cnt;
        hs_low = 0;
        first_low = -1;
        vis_cnt = 0;
        for (int i = 0; i < A_HT; i++) begin
            if (i > 0) cyc(1, 1, 0, 1, 0, 0);
            checks++;
            if (got_a !== exp_a()) begin
                failures++;
                $display("FAIL line_pos got=%h exp=%h", got_a, exp_a());
            end
            if (!hs_a) begin
                if (first_low < 0) first_low = int'(col_a);
                hs_low++;
            end
            if (vis_a) vis_cnt++;
        end
        checks++;
        if (hs_low != 96) begin
            failures++;
            $display("FAIL hsync_width got=%0d exp=96", hs_low);
        end
        checks++;
        if (first_low != 656) begin
            failures++;
            $display("FAIL hsync_start got=%0d exp=656", first_low);
        end
        checks++;
        if (vis_cnt != 640) begin
            failures++;
            $display("FAIL visible_width got=%0d exp=640", vis_cnt);
        end
    endtask

    task automatic test_pix_div();
        int m_pulses;
        int d_pulses;
        int doubles;
        bit prev_fs;
        logic [9:0] pc;
        bit e;
        m_pulses = 0;
        d_pulses = 0;
        doubles = 0;
        prev_fs = 0;
        pc = col_a;
        for (int i = 0; i < 1200; i++) begin
            e = ((i % 4) == 0);
            cyc(1, e, 0, 1, e, 0);
            checks++;
            if (got_a !== exp_a()) begin
                failures++;
                $display("FAIL div_a got=%h exp=%h", got_a, exp_a());
            end
            checks++;
            if ({got_b, pat_b} !== {exp_b(), exp_pat_b()}) begin
                failures++;
                $display("FAIL div_b got=%h exp=%h", {got_b, pat_b},
                         {exp_b(), exp_pat_b()});
            end
            if (!e) begin
                checks++;
                if (col_a !== pc) begin
                    failures++;
                    $display("FAIL div_hold got=%0d exp=%0d", col_a, pc);
                end
            end
            pc = col_a;
            if (mfs_b) m_pulses++;
            if (fs_b) d_pulses++;
            if (fs_b && prev_fs) doubles++;
            prev_fs = fs_b;
        end
        checks++;
        if (doubles != 0) begin
            failures++;
            $display("FAIL div_fs_width got=%0d exp=0", doubles);
        end
        checks++;
        if (d_pulses != m_pulses) begin
            failures++;
            $display("FAIL div_fs_count got=%0d exp=%0d", d_pulses, m_pulses);
        end
    endtask

    task automatic test_frame();
        int last;
        int npulse;
        int vs_low;
        last = -1;
        npulse = 0;
        vs_low = 0;
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3 * B_FR + 1; i++) begin
            cyc(1, 0, 0, 1, 1, 0);
            checks++;
            if (got_b !== exp_b()) begin
                failures++;
                $display("FAIL frame_pos got=%h exp=%h", got_b, exp_b());
            end
            if (fs_b) begin
                if (last >= 0) begin
                    checks++;
                    if (i - last != B_FR) begin
                        failures++;
                        $display("FAIL frame_gap got=%0d exp=%0d",
                                 i - last, B_FR);
                    end
                end
                last = i;
                npulse++;
                if (npulse == 2) begin
                    checks++;
                    if (vs_low != 2 * B_HT) begin
                        failures++;
                        $display("FAIL vsync_width got=%0d exp=%0d",
                                 vs_low, 2 * B_HT);
                    end
                end
            end
            if (npulse == 1 && !vs_b) vs_low++;
        end
        checks++;
        if (npulse != 4) begin
            failures++;
            $display("FAIL frame_pulses got=%0d exp=4", npulse);
        end
    endtask

    task automatic test_patterns(input bit with_hold);
        int exp_seq[9];
        int frames;
        logic [1:0] prev_pat;
        bit h;
        bit e;
        if (with_hold) exp_seq = '{0, 0, 1, 1, 1, 1, 1, 2, 2};
        else exp_seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        frames = 0;
        prev_pat = 2'd0;
        h = 0;
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9 * B_FR * 8 && frames < 9; i++) begin
            e = with_hold ? ($urandom_range(0, 3) != 0) : 1'b1;
            cyc(1, 0, 0, 1, e, h);
            checks++;
            if ({got_b, pat_b} !== {exp_b(), exp_pat_b()}) begin
                failures++;
                $display("FAIL pat_model got=%h exp=%h", {got_b, pat_b},
                         {exp_b(), exp_pat_b()});
            end
            checks++;
            if (pat_b !== prev_pat && !fs_b) begin
                failures++;
                $display("FAIL pat_midframe got=%0d exp=%0d", pat_b, prev_pat);
            end
            prev_pat = pat_b;
            if (fs_b) begin
                frames++;
                checks++;
                if (pat_b !== 2'(exp_seq[frames-1])) begin
                    failures++;
                    $display("FAIL pat_seq frame=%0d got=%0d exp=%0d",
                             frames, pat_b, exp_seq[frames-1]);
                end
                if (with_hold) h = (frames >= 3 && frames <= 5);
            end
        end
        checks++;
        if (frames != 9) begin
            failures++;
            $display("FAIL pat_timeout got=%0d exp=9", frames);
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            cyc(1, 1, 0, 1, 0, 0);
            if (col_a == 10'd300) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL mid_reach_a got=%0d exp=300", col_a);
        end
        cyc(0, 1, 0, 1, 0, 0);
        checks++;
        if ({got_a, pat_a} !== {10'd799, 10'd524, 4'b1100, 2'd0}) begin
            failures++;
            $display("FAIL mid_reset_a got=%h exp=%h", {got_a, pat_a},
                     {10'd799, 10'd524, 4'b1100, 2'd0});
        end
        cyc(1, 1, 0, 1, 0, 0);
        checks++;
        if (got_a !== {10'd0, 10'd0, 4'b1111}) begin
            failures++;
            $display("FAIL mid_release_a got=%h exp=%h", got_a,
                     {10'd0, 10'd0, 4'b1111});
        end
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            cyc(1, 0, 0, 1, 1, 0);
            if (row_b == 10'd2 && col_b == 10'd5) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL mid_reach_b got=%0d/%0d exp=5/2", col_b, row_b);
        end
        cyc(1, 0, 0, 0, 1, 1);
        checks++;
        if ({got_b, pat_b} !== {10'd14, 10'd8, 4'b1100, 2'd0}) begin
            failures++;
            $display("FAIL mid_reset_b got=%h exp=%h", {got_b, pat_b},
                     {10'd14, 10'd8, 4'b1100, 2'd0});
        end
        for (int i = 0; i < 2 * B_FR + 5; i++) begin
            cyc(1, 0, 0, 1, 1, 0);
            checks++;
            if ({got_b, pat_b} !== {exp_b(), exp_pat_b()}) begin
                failures++;
                $display("FAIL mid_resume_b got=%h exp=%h", {got_b, pat_b},
                         {exp_b(), exp_pat_b()});
            end
        end
    endtask

    initial begin
        rst_a_n = 0; en_a = 0; hold_a = 0;
        rst_b_n = 0; en_b = 0; hold_b = 0;
        @(negedge clk);
        test_reset();
        test_first_cycle();
        test_line();
        test_pix_div();
        test_frame();
        test_patterns(0);
        test_patterns(1);
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 The block SHALL have parameter FRAMES_PER_PATTERN, default 60: frames each test pattern is held.
REQ-002 The block SHALL have parameter NUM_PATTERNS, default 4: patterns cycled, indices 0..NUM_PATTERNS-1.
REQ-003 The block SHALL have port clk_i, input, 1: single clock; the design has one clock; all logic on the rising edge.
REQ-004 The block SHALL have port rst_n_i, input, 1: reset, synchronous, active-low.
REQ-005 The block SHALL have port pix_en_i, input, 1: pixel-clock enable; counters advance only in cycles where it is high.
REQ-006 The block SHALL have port hold_i, input, 1: freeze the current pattern index.
REQ-007 The block SHALL have port column_o, output, 10: horizontal position, 0..799.
REQ-008 The block SHALL have port row_o, output, 10: vertical position, 0..524.
REQ-009 The block SHALL have port hsync_o, output, 1: horizontal sync, active-low.
REQ-010 The block SHALL have port vsync_o, output, 1: vertical sync, active-low.
REQ-011 The block SHALL have port visible_o, output, 1: current position is inside 640x480.
REQ-012 The block SHALL have port frame_start_o, output, 1: single-clk pulse at the start of a frame.
REQ-013 The block SHALL have port pattern_o, output, 2: active test-pattern index.

Function
REQ-014 Horizontal timing SHALL be 640 visible + 16 front porch + 96 sync + 48 back porch = 800 columns.
REQ-015 Vertical timing SHALL be 480 visible + 10 front porch + 2 sync + 33 back porch = 525 rows.
REQ-016 When pix_en_i=1, column_o SHALL increment by 1, wrapping 799->0.
REQ-017 When column_o wraps, row_o SHALL increment by 1, wrapping 524->0.
REQ-018 When pix_en_i=0, all counters and outputs SHALL hold, except frame_start_o, which SHALL deassert.
REQ-019 hsync_o SHALL be 0 iff 656<=column_o<=751.
REQ-020 vsync_o SHALL be 0 iff 490<=row_o<=491.
REQ-021 visible_o SHALL be 1 iff column_o<640 and row_o<480.
REQ-022 hsync_o, vsync_o and visible_o SHALL be consistent with column_o/row_o in the same cycle, with zero skew.
REQ-023 frame_start_o SHALL be 1 for exactly one clk cycle: the cycle in which the counters first read (0,0) after a pix_en_i-qualified wrap from (799,524).
REQ-024 A frame counter SHALL increment on each frame wrap.
REQ-025 When the frame counter reaches FRAMES_PER_PATTERN-1 and wraps, with hold_i=0, pattern_o SHALL increment, wrapping NUM_PATTERNS-1->0.
REQ-026 When hold_i=1, pattern_o SHALL be frozen and the frame counter SHALL be held.
REQ-027 pattern_o SHALL change only in the same cycle frame_start_o asserts, never mid-frame.
REQ-028 When hold_i deasserts, the frame count SHALL resume from its held value.
REQ-029 All comparisons SHALL be unsigned, 10-bit.
REQ-030 The frame counter width SHALL be $clog2(FRAMES_PER_PATTERN).

Reset
REQ-031 While rst_n_i=0 at a clock edge, the outputs SHALL be column_o=799, row_o=524, hsync_o=1, vsync_o=1, visible_o=0, frame_start_o=0, pattern_o=0, and the frame counter SHALL be 0.
REQ-032 After reset release, the first pix_en_i=1 cycle SHALL move the counters to (0,0) and assert frame_start_o.
REQ-033 Reset asserted mid-frame SHALL override pix_en_i and return all state to the REQ-031 values at the next edge.

Structure
REQ-034 The timing constants (visible, porch, sync, total for H and V) and the sync polarity SHALL live in a shared include, vga_timing.vh, so that pattern generators use the same values.
REQ-035 Sub-module wrap_counter (parameters WIDTH, MAX; ports clk_i, rst_n_i, en_i, count_o, wrap_o) SHALL be instantiated three times: horizontal, vertical and frame.
REQ-036 All outputs SHALL be driven from registers or from decode of registered counters; there SHALL be no combinational path from any input to any output.

Verification
REQ-037 The bench SHALL check: reset release, pix_en_i held 1 -> frame_start_o high on the first post-reset cycle, column_o=0, row_o=0, visible_o=1.
REQ-038 The bench SHALL check: one full line with pix_en_i=1 -> hsync_o low for exactly 96 cycles starting at column 656; visible_o high for 640 cycles.
REQ-039 The bench SHALL check: one full frame -> 420000 cycles between frame_start_o pulses; vsync_o low for exactly rows 490-491 (1600 cycles).
REQ-040 The bench SHALL check: pix_en_i 1-in-4 (100 MHz clk, 25 MHz pixels) -> counters hold 3 of every 4 cycles; frame_start_o is still a single clk-cycle pulse.
REQ-041 The bench SHALL check: FRAMES_PER_PATTERN=2 over 9 frames -> pattern_o sequence 0,0,1,1,2,2,3,3,0, changing only with frame_start_o; with hold_i=1 over frames 3-5, the sequence stalls and resumes without skipping.
REQ-042 The bench SHALL check: reset asserted at column=300, row=200 -> REQ-031 values the next cycle; normal sequencing from (0,0) after release.
